fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It is the producer of the decode stage's `instruction` / `PCPlus4D` inputs and the consumer of its `PCSrcD` / `PCBranchD` redirect outputs. It owns the program counter and runs a valid/ready request handshake to a variable-latency instruction memory. It honours decode stalls and flushes the wrong-path fetch on a taken branch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
StallD  input  1  hazard unit: hold IF/ID contents and PC this cycle
PCSrcD  input  1  decode: taken branch in decode this cycle
PCBranchD  input  32  decode: branch target
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address; must stay stable while imem_req=1 and imem_ready=0
imem_ready  input  1  memory: imem_rdata valid; completes the current request
imem_rdata  input  32  fetched instruction word
InstrD  output  32  IF/ID instruction to decode
PCPlus4D  output  32  IF/ID PC+4 to decode
ValidD  output  1  IF/ID holds a real instruction (0 = bubble, InstrD=NOP)
StallF  output  1  fetch has no word for decode this cycle (monitoring/hazard visibility)

Behaviour:
- **Reset** (rst=1 at edge): PCF=RESET_PC, state=FETCH, kill=0, buffer empty, InstrD=32'h0, PCPlus4D=32'h0, ValidD=0. `imem_ready` sampled in a reset cycle is ignored. Instruction memory shares `rst`, so nothing is outstanding after reset.
- **Address path:** `imem_addr={PCF[31:2],2'b00}`. PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- **Redirect:** redirect = PCSrcD & ValidD & ~StallD. Redirect has priority over every other event in the same cycle.
- **State FETCH:** imem_req=1.
  - imem_ready=1, no redirect, kill=0, StallD=0: IF/ID loads InstrD=imem_rdata, PCPlus4D=PCF+4, ValidD=1; PCF<=PCF+4; stay FETCH.
  - imem_ready=1, StallD=1: word goes to the skid buffer (buf_instr, buf_pc4); go to HOLD.
  - imem_ready=0 and redirect: latch tgt<=PCBranchD, kill<=1; keep the address stable until the request completes.
  - imem_ready=1 and (redirect or kill=1): discard the word. PCF<=PCBranchD if redirect, else tgt. Clear kill.
- **State HOLD:** imem_req=0.
  - StallD=0: load the buffer into IF/ID (ValidD=1), PCF<=buf_pc4, go to FETCH.
  - Redirect: discard the buffer, PCF<=PCBranchD, go to FETCH.
- **IF/ID update priority** (highest first):
  1. rst
  2. redirect → InstrD=0, ValidD=0, PCPlus4D=0 (branch-shadow flush)
  3. StallD=1 → hold
  4. word delivered → load
  5. otherwise → bubble (InstrD=0, ValidD=0, PCPlus4D unchanged)
- **StallF:** 1 whenever the stage is not delivering a word into IF/ID this cycle while StallD=0.
- **Latency:** with single-cycle memory (imem_ready tied 1), one instruction enters IF/ID per clock. A redirect costs exactly one bubble.
- Back-to-back redirects are each honoured. The latest PCBranchD overwrites tgt.
- Reset mid-request or mid-HOLD drops all in-flight state immediately.

Decomposition:
- **Shared package (mips_pkg):** NOP_INSTR=32'h0, RESET_PC default, state encoding {FETCH, HOLD}, instruction width 32.
- **Sub-module if_id_reg:** 32+32+1 bit register with sync rst, en (=~StallD), clr (=redirect), and bubble load. Reusable for the other pipeline registers.

Test Plan:
1. **Reset then free-run:** rst 2 cycles, imem_ready=1, rdata=addr+32'h1000 → imem_addr 0,4,8,…; InstrD=32'h1000,32'h1004,…; PCPlus4D=4,8,…; ValidD=1 from the 2nd cycle after reset.
2. **Variable latency:** imem_ready low 3 cycles per request → imem_addr held stable and imem_req=1 throughout; ValidD=0 and StallF=1 in wait cycles; no duplicated or skipped PC.
3. **Stall while word returns:** StallD=1 for 2 cycles coincident with ready at PC=8 → IF/ID held, imem_req=0 in HOLD; after release InstrD=mem[8], then fetch resumes at 12.
4. **Taken branch, fast memory:** ValidD=1, PCSrcD=1, PCBranchD=32'h40 → next IF/ID is a bubble (InstrD=0, ValidD=0), next imem_addr=32'h40, then InstrD=mem[0x40].
5. **Branch during outstanding request:** request at 0x10 pending, redirect to 0x80, ready 2 cycles later → word from 0x10 never reaches IF/ID; the next request address is 0x80.
6. **Wrap and mid-op reset:** PCF=32'hFFFF_FFFC → PCPlus4D=0 and next addr 0. Assert rst in HOLD → buffer dropped, ValidD=0, imem_addr=RESET_PC on the following cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS pipeline stages
package mips_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline register (instr, pc+4, valid) with hold, flush and bubble insertion
module if_id_reg
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic            load,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc4_in,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] pc4_out,
   output logic            valid_out
);

   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic            valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (clr) begin
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (en) begin
         if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
         end else begin
            // a bubble keeps the old pc+4 so only the valid/instr pair changes
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out = instr_q;
   assign pc4_out   = pc4_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with variable-latency imem handshake, skid buffer and IF/ID register
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallD,
   input  logic            PCSrcD,
   input  logic [XLEN-1:0] PCBranchD,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
   output logic            StallF
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pcf_q, pcf_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            kill_q, kill_d;
   logic [XLEN-1:0] buf_instr_q, buf_instr_d;
   logic [XLEN-1:0] buf_pc4_q, buf_pc4_d;

   logic            redirect;
   logic [XLEN-1:0] pcf_plus4;
   logic            deliver;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc4;

   assign redirect  = PCSrcD & ValidD & ~StallD;
   assign pcf_plus4 = pcf_q + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH;
         pcf_q       <= RESET_PC;
         tgt_q       <= '0;
         kill_q      <= 1'b0;
         buf_instr_q <= NOP_INSTR;
         buf_pc4_q   <= '0;
      end else begin
         state_q     <= state_d;
         pcf_q       <= pcf_d;
         tgt_q       <= tgt_d;
         kill_q      <= kill_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pcf_d       = pcf_q;
      tgt_d       = tgt_q;
      kill_d      = kill_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;
      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               if (redirect) begin
                  pcf_d  = PCBranchD;
                  kill_d = 1'b0;
               end else if (kill_q) begin
                  pcf_d  = tgt_q;
                  kill_d = 1'b0;
               end else if (StallD) begin
                  buf_instr_d = imem_rdata;
                  buf_pc4_d   = pcf_plus4;
                  state_d     = HOLD;
               end else begin
                  pcf_d = pcf_plus4;
               end
            end else if (redirect) begin
               // the request in flight must finish at its own address; its word is dropped later
               tgt_d  = PCBranchD;
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               pcf_d   = PCBranchD;
               state_d = FETCH;
            end else if (!StallD) begin
               pcf_d   = buf_pc4_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == FETCH);
      imem_addr = word_align(pcf_q);
      id_instr  = imem_rdata;
      id_pc4    = pcf_plus4;
      deliver   = 1'b0;
      if (state_q == FETCH) begin
         deliver = imem_ready & ~kill_q & ~redirect & ~StallD;
      end else begin
         deliver  = ~StallD & ~redirect;
         id_instr = buf_instr_q;
         id_pc4   = buf_pc4_q;
      end
      StallF = ~StallD & ~deliver;
   end

   if_id_reg u_if_id (
      .clk       (clk),
      .rst       (rst),
      .en        (~StallD),
      .clr       (redirect),
      .load      (deliver),
      .instr_in  (id_instr),
      .pc4_in    (id_pc4),
      .instr_out (InstrD),
      .pc4_out   (PCPlus4D),
      .valid_out (ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with program-order stream model
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        StallF;

   int vectors     = 0;
   int miscompares = 0;
   int lat         = 0;
   int wcnt        = 0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .StallD     (StallD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .StallF     (StallF)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h0000_1000;
   endfunction

   // memory: each request waits 'lat' cycles before completing
   assign imem_ready = imem_req && (wcnt >= lat);
   assign imem_rdata = mem_word(imem_addr);

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      logic s_rs, s_done, s_req;
      forever begin
         @(negedge clk);
         s_rs   = rst;
         s_done = imem_req & imem_ready;
         s_req  = imem_req;
         @(posedge clk);
         #1;
         if (s_rs || s_done) wcnt = 0;
         else if (s_req)     wcnt = wcnt + 1;
      end
   end

   // stream model: words reach decode in program order from exp_pc, restarting at each redirect
   logic        have_prev = 1'b0;
   logic        p_rst, p_stall, p_pcsrc, p_valid, p_req, p_ready, p_stallf, p_redir, new_word;
   logic [31:0] p_branch, p_addr, p_instr, p_pc4;
   logic [31:0] exp_pc = RESET_PC;

   always @(negedge clk) begin
      if (have_prev) begin
         if (p_rst) begin
            chk1 ("rst_valid", ValidD, 1'b0);
            chk32("rst_instr", InstrD, 32'h0);
            chk32("rst_pc4",   PCPlus4D, 32'h0);
            chk32("rst_addr",  imem_addr, RESET_PC);
            exp_pc = RESET_PC;
         end else begin
            p_redir  = p_pcsrc & p_valid & ~p_stall;
            new_word = 1'b0;
            if (p_redir) begin
               chk1 ("flush_valid", ValidD, 1'b0);
               chk32("flush_instr", InstrD, 32'h0);
               chk32("flush_pc4",   PCPlus4D, 32'h0);
               exp_pc = p_branch;
            end else if (p_stall) begin
               chk1 ("hold_valid", ValidD, p_valid);
               chk32("hold_instr", InstrD, p_instr);
               chk32("hold_pc4",   PCPlus4D, p_pc4);
            end else if (ValidD) begin
               new_word = 1'b1;
               chk32("stream_instr", InstrD, mem_word(exp_pc));
               chk32("stream_pc4",   PCPlus4D, exp_pc + 32'd4);
               exp_pc = exp_pc + 32'd4;
            end else begin
               chk32("bubble_instr", InstrD, 32'h0);
               chk32("bubble_pc4",   PCPlus4D, p_pc4);
            end
            chk1("stallf", p_stallf, !p_stall && !new_word);
            if (p_req && !p_ready) begin
               chk1 ("req_held",    imem_req, 1'b1);
               chk32("addr_stable", imem_addr, p_addr);
            end
         end
      end
      p_rst    = rst;
      p_stall  = StallD;
      p_pcsrc  = PCSrcD;
      p_branch = PCBranchD;
      p_valid  = ValidD;
      p_req    = imem_req;
      p_ready  = imem_ready;
      p_addr   = imem_addr;
      p_instr  = InstrD;
      p_pc4    = PCPlus4D;
      p_stallf = StallF;
      have_prev = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk32("lit_reset_addr", imem_addr, 32'h0);
      chk1 ("lit_reset_valid", ValidD, 1'b0);

      // free run with single-cycle memory
      tick(); @(negedge clk);
      chk32("lit_i0", InstrD, 32'h1000);
      chk32("lit_p0", PCPlus4D, 32'h4);
      chk1 ("lit_v0", ValidD, 1'b1);
      tick(); StallD = 1'b1; @(negedge clk);
      chk32("lit_i1", InstrD, 32'h1004);
      chk32("lit_a8", imem_addr, 32'h8);

      // stall while the word for PC=8 returns
      tick(); @(negedge clk);
      chk1 ("lit_hold_req", imem_req, 1'b0);
      chk32("lit_hold_i", InstrD, 32'h1004);
      tick(); StallD = 1'b0; @(negedge clk);
      chk1 ("lit_hold_req2", imem_req, 1'b0);
      tick(); @(negedge clk);
      chk32("lit_buf_i", InstrD, 32'h1008);
      chk32("lit_buf_a", imem_addr, 32'hC);
      tick(); PCSrcD = 1'b1; PCBranchD = 32'h40; @(negedge clk);
      chk32("lit_i3", InstrD, 32'h100C);

      // taken branch with fast memory: exactly one bubble
      tick(); PCSrcD = 1'b0; @(negedge clk);
      chk1 ("lit_br_v", ValidD, 1'b0);
      chk32("lit_br_a", imem_addr, 32'h40);
      tick(); lat = 3; @(negedge clk);
      chk32("lit_br_i", InstrD, 32'h1040);
      chk32("lit_br_p", PCPlus4D, 32'h44);
      chk1 ("lit_wait_stallf", StallF, 1'b1);

      // three wait cycles per request
      for (int i = 0; i < 3; i++) begin
         tick(); @(negedge clk);
         chk32("lit_wait_a", imem_addr, 32'h44);
         chk1 ("lit_wait_v", ValidD, 1'b0);
      end
      tick(); PCSrcD = 1'b1; PCBranchD = 32'h80; @(negedge clk);
      chk32("lit_slow_i", InstrD, 32'h1044);
      chk32("lit_slow_a", imem_addr, 32'h48);

      // redirect while the request at 0x48 is outstanding
      tick(); PCSrcD = 1'b0; @(negedge clk);
      chk32("lit_kill_a", imem_addr, 32'h48);
      tick(); tick(); @(negedge clk);
      chk1("lit_kill_stallf", StallF, 1'b1);
      tick(); lat = 0; @(negedge clk);
      chk32("lit_tgt_a", imem_addr, 32'h80);
      chk1 ("lit_tgt_v", ValidD, 1'b0);
      tick(); PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC; @(negedge clk);
      chk32("lit_tgt_i", InstrD, 32'h1080);

      // address wrap, then reset while in HOLD
      tick(); PCSrcD = 1'b0; @(negedge clk);
      chk32("lit_wrap_a0", imem_addr, 32'hFFFF_FFFC);
      tick(); StallD = 1'b1; @(negedge clk);
      chk32("lit_wrap_i", InstrD, 32'h0000_0FFC);
      chk32("lit_wrap_p", PCPlus4D, 32'h0);
      chk32("lit_wrap_a", imem_addr, 32'h0);
      tick(); @(negedge clk);
      chk1("lit_hold2_req", imem_req, 1'b0);
      tick(); rst = 1'b1; StallD = 1'b0; @(negedge clk);
      tick(); rst = 1'b0; @(negedge clk);
      chk1 ("lit_mrst_v", ValidD, 1'b0);
      chk32("lit_mrst_a", imem_addr, RESET_PC);
      chk1 ("lit_mrst_req", imem_req, 1'b1);

      // mixed stalls and redirects with two-cycle memory
      lat = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         StallD    = (i % 7 == 3) || (i % 11 == 5);
         PCSrcD    = (i % 5 == 2);
         PCBranchD = 32'h200 + 32'(i * 16);
         @(negedge clk);
      end
      tick(); StallD = 1'b0; PCSrcD = 1'b0; lat = 0;
      for (int i = 0; i < 6; i++) tick();
      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
